// File: rtl/uart_rx_ctrl.sv
// UART RX sequencer: tracks oversample edges and bit position, strobes the
// per-bit checkers at the sample point, and reports one verdict pulse per frame.
module uart_rx_ctrl #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               PAR_EN,
  input  logic               start_glitch,
  input  logic               par_error,
  input  logic               stop_error,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic               data_samp_EN,
  output logic               start_check_EN,
  output logic               deser_EN,
  output logic               par_check_EN,
  output logic               stop_check_EN,
  output logic               data_valid,
  output logic               frame_error,
  output logic               parity_error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;

  localparam int                 BIT_W  = 4;
  localparam logic [PRESC_W-1:0] P_ONE  = PRESC_W'(1);
  localparam logic [BIT_W-1:0]   B_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0]   B_LAST = BIT_W'(DATA_W - 1);

  logic [2:0]         r_state,    w_state_nxt;
  logic [PRESC_W-1:0] r_edge_cnt, w_edge_nxt;
  logic [PRESC_W-1:0] r_presc,    w_presc_nxt;
  logic [BIT_W-1:0]   r_bit_cnt,  w_bit_nxt;
  logic               r_par_en,   w_par_en_nxt;
  logic               r_par_flag;
  logic [PRESC_W-1:0] w_sp, w_sp_nxt;
  logic               w_wrap;

  logic r_start_en, r_deser_en, r_par_chk_en, r_stop_en;
  logic r_data_valid, r_frame_err, r_parity_err;

  // Sample point sits just past mid-bit: Prescale/2 + 1.
  assign w_sp     = {1'b0, r_presc[PRESC_W-1:1]} + P_ONE;
  assign w_sp_nxt = {1'b0, w_presc_nxt[PRESC_W-1:1]} + P_ONE;
  assign w_wrap   = (r_edge_cnt == r_presc - P_ONE);

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_edge_nxt   = r_edge_cnt;
    w_bit_nxt    = r_bit_cnt;
    w_presc_nxt  = r_presc;
    w_par_en_nxt = r_par_en;

    if (r_state != S_IDLE) begin
      w_edge_nxt = w_wrap ? '0 : r_edge_cnt + P_ONE;
      w_bit_nxt  = w_wrap ? r_bit_cnt + B_ONE : r_bit_cnt;
    end

    case (r_state)
      S_IDLE: begin
        w_edge_nxt = '0;
        // The detecting cycle is edge 0, so the first START cycle is edge 1.
        if (!RX_IN) begin
          w_state_nxt  = S_START;
          w_edge_nxt   = P_ONE;
          w_presc_nxt  = Prescale;
          w_par_en_nxt = PAR_EN;
        end
      end
      S_START: begin
        if ((r_edge_cnt == w_sp + P_ONE) && start_glitch) begin
          w_state_nxt = S_IDLE;
          w_edge_nxt  = '0;
        end else if (w_wrap) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_wrap && (r_bit_cnt == B_LAST)) begin
          w_state_nxt = r_par_en ? S_PARITY : S_STOP;
          w_bit_nxt   = '0;
        end
      end
      S_PARITY: begin
        if (w_wrap) begin
          w_state_nxt = S_STOP;
          w_bit_nxt   = '0;
        end
      end
      S_STOP: begin
        if (r_edge_cnt == w_sp) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        w_state_nxt = S_IDLE;
        w_edge_nxt  = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_edge_nxt  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_edge_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_presc      <= '0;
      r_par_en     <= 1'b0;
      r_par_flag   <= 1'b0;
      r_start_en   <= 1'b0;
      r_deser_en   <= 1'b0;
      r_par_chk_en <= 1'b0;
      r_stop_en    <= 1'b0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_edge_cnt <= w_edge_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_presc    <= w_presc_nxt;
      r_par_en   <= w_par_en_nxt;

      if ((r_state == S_PARITY) && (r_edge_cnt == w_sp + P_ONE))
        r_par_flag <= par_error;
      else if (r_state == S_CHECK)
        r_par_flag <= 1'b0;

      // Strobes decode the upcoming state/edge so they line up with edge_cnt.
      r_start_en   <= (w_state_nxt == S_START)  && (w_edge_nxt == w_sp_nxt);
      r_deser_en   <= (w_state_nxt == S_DATA)   && (w_edge_nxt == w_sp_nxt);
      r_par_chk_en <= (w_state_nxt == S_PARITY) && (w_edge_nxt == w_sp_nxt);
      r_stop_en    <= (w_state_nxt == S_STOP)   && (w_edge_nxt == w_sp_nxt);

      // Stop error outranks parity error when both are present.
      r_frame_err  <= (r_state == S_CHECK) && stop_error;
      r_parity_err <= (r_state == S_CHECK) && !stop_error && r_par_flag;
      r_data_valid <= (r_state == S_CHECK) && !stop_error && !r_par_flag;
    end
  end

  assign edge_cnt       = r_edge_cnt;
  assign data_samp_EN   = (r_state != S_IDLE);
  assign start_check_EN = r_start_en;
  assign deser_EN       = r_deser_en;
  assign par_check_EN   = r_par_chk_en;
  assign stop_check_EN  = r_stop_en;
  assign data_valid     = r_data_valid;
  assign frame_error    = r_frame_err;
  assign parity_error   = r_parity_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl; emulates the registered start/parity/stop
// checkers and counts strobes and verdict pulses per scenario.
module tb_uart_rx_ctrl;

  localparam int DATA_W  = 8;
  localparam int PRESC_W = 6;

  logic               CLK = 1'b0;
  logic               Reset;
  logic               RX_IN;
  logic [PRESC_W-1:0] Prescale;
  logic               PAR_EN;
  logic               start_glitch;
  logic               par_error;
  logic               stop_error;
  logic [PRESC_W-1:0] edge_cnt;
  logic               data_samp_EN;
  logic               start_check_EN;
  logic               deser_EN;
  logic               par_check_EN;
  logic               stop_check_EN;
  logic               data_valid;
  logic               frame_error;
  logic               parity_error;

  uart_rx_ctrl #(.DATA_W(DATA_W), .PRESC_W(PRESC_W)) dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .RX_IN          (RX_IN),
    .Prescale       (Prescale),
    .PAR_EN         (PAR_EN),
    .start_glitch   (start_glitch),
    .par_error      (par_error),
    .stop_error     (stop_error),
    .edge_cnt       (edge_cnt),
    .data_samp_EN   (data_samp_EN),
    .start_check_EN (start_check_EN),
    .deser_EN       (deser_EN),
    .par_check_EN   (par_check_EN),
    .stop_check_EN  (stop_check_EN),
    .data_valid     (data_valid),
    .frame_error    (frame_error),
    .parity_error   (parity_error)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit cfg_glitch, cfg_par, cfg_stop;
  bit prev_start, prev_par, prev_stop;
  int cur_presc;
  int c_start, c_stop;
  int n_deser, first_deser, last_deser, gap_bad;
  int n_start, start_cyc, n_par, n_stop;
  int n_dv, dv_cyc, n_fe, fe_cyc, n_pe, pe_cyc, excl_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {18'b0, edge_cnt, data_samp_EN, start_check_EN, deser_EN, par_check_EN,
            stop_check_EN, data_valid, frame_error, parity_error};
  endfunction

  task automatic clr_mon();
    n_deser = 0; first_deser = -1; last_deser = 0; gap_bad = 0;
    n_start = 0; start_cyc = -1; n_par = 0; n_stop = 0;
    n_dv = 0; dv_cyc = -1; n_fe = 0; fe_cyc = -1; n_pe = 0; pe_cyc = -1;
    excl_bad = 0;
  endtask

  // Advance one cycle, sample 1ns after the edge, answer last cycle's strobes.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    start_glitch = prev_start & cfg_glitch;
    par_error    = prev_par   & cfg_par;
    stop_error   = prev_stop  & cfg_stop;
    prev_start   = start_check_EN;
    prev_par     = par_check_EN;
    prev_stop    = stop_check_EN;
    if (deser_EN) begin
      if (n_deser == 0) first_deser = cyc;
      else if (cyc - last_deser != cur_presc) gap_bad++;
      last_deser = cyc;
      n_deser++;
    end
    if (start_check_EN) begin n_start++; start_cyc = cyc; end
    if (par_check_EN)   n_par++;
    if (stop_check_EN)  n_stop++;
    if (data_valid)     begin n_dv++; dv_cyc = cyc; end
    if (frame_error)    begin n_fe++; fe_cyc = cyc; end
    if (parity_error)   begin n_pe++; pe_cyc = cyc; end
    if (int'(data_valid) + int'(frame_error) + int'(parity_error) > 1) excl_bad++;
  endtask

  task automatic send_frame(input int presc, input bit par_en, input logic [7:0] data,
                            input bit par_err, input bit stop_err);
    cur_presc  = presc;
    Prescale   = presc[PRESC_W-1:0];
    PAR_EN     = par_en;
    cfg_glitch = 1'b0;
    cfg_par    = par_err;
    cfg_stop   = stop_err;
    c_start    = cyc;
    RX_IN      = 1'b0;
    tick();
    check("edge_after_start", edge_cnt, 1);
    repeat (presc - 1) tick();
    for (int i = 0; i < DATA_W; i++) begin
      RX_IN = data[i];
      repeat (presc) tick();
    end
    if (par_en) begin
      RX_IN = ^data;
      repeat (presc) tick();
    end
    c_stop = cyc;
    RX_IN  = 1'b1;
    repeat (presc) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0;
    start_glitch = 1'b0; par_error = 1'b0; stop_error = 1'b0;
    cfg_glitch = 0; cfg_par = 0; cfg_stop = 0;
    prev_start = 0; prev_par = 0; prev_stop = 0;
    cur_presc = 8;
    clr_mon();
    repeat (3) tick();
    check("reset_outs", outs(), 0);
    Reset = 1'b1;
    repeat (3) tick();
    check("idle_outs", outs(), 0);

    // Prescale 8, no parity, clean frame.
    clr_mon();
    send_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0);
    repeat (3) tick();
    check("p8_deser_count", n_deser, 8);
    check("p8_first_deser", first_deser - c_start, 13);
    check("p8_deser_gaps", gap_bad, 0);
    check("p8_start_en", n_start, 1);
    check("p8_par_en", n_par, 0);
    check("p8_stop_en", n_stop, 1);
    check("p8_dv", n_dv, 1);
    check("p8_errs", n_fe + n_pe, 0);
    check("p8_dv_latency", dv_cyc - c_stop, 7);

    // Start glitch: two low cycles, checker reports a glitch.
    clr_mon();
    cur_presc = 8; Prescale = 6'd8; PAR_EN = 1'b0;
    cfg_glitch = 1'b1; cfg_par = 0; cfg_stop = 0;
    c_start = cyc;
    RX_IN = 1'b0;
    repeat (2) tick();
    RX_IN = 1'b1;
    repeat (4) tick();
    check("glitch_edge6", edge_cnt, 6);
    check("glitch_samp_busy", data_samp_EN, 1);
    tick();
    check("glitch_back_idle", {data_samp_EN, edge_cnt}, 0);
    repeat (80) tick();
    check("glitch_start_en", n_start, 1);
    check("glitch_no_deser", n_deser, 0);
    check("glitch_no_pulse", n_dv + n_fe + n_pe, 0);
    cfg_glitch = 1'b0;

    // Prescale 16 with parity error.
    clr_mon();
    send_frame(16, 1'b1, 8'hC3, 1'b1, 1'b0);
    repeat (3) tick();
    check("p16_par_en", n_par, 1);
    check("p16_deser_count", n_deser, 8);
    check("p16_parity_err", n_pe, 1);
    check("p16_pe_latency", pe_cyc - c_stop, 11);
    check("p16_no_dv_fe", n_dv + n_fe, 0);

    // Prescale 32, parity and stop errors together.
    clr_mon();
    send_frame(32, 1'b1, 8'h81, 1'b1, 1'b1);
    repeat (3) tick();
    check("p32_frame_err", n_fe, 1);
    check("p32_fe_latency", fe_cyc - c_stop, 19);
    check("p32_no_pe_dv", n_pe + n_dv, 0);

    // Parity flag must not leak into the next clean frame.
    clr_mon();
    send_frame(32, 1'b1, 8'h7E, 1'b0, 1'b0);
    repeat (3) tick();
    check("p32_clean_dv", n_dv, 1);
    check("p32_clean_errs", n_fe + n_pe, 0);

    // Back-to-back frames at Prescale 8.
    clr_mon();
    send_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0);
    send_frame(8, 1'b0, 8'h3C, 1'b0, 1'b0);
    repeat (3) tick();
    check("b2b_dv", n_dv, 2);
    check("b2b_deser", n_deser, 16);
    check("b2b_second_start", start_cyc - c_start, 5);
    check("b2b_errs", n_fe + n_pe, 0);

    // Reset in the middle of data bit 3.
    clr_mon();
    cur_presc = 8; Prescale = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (8) tick();
    RX_IN = 1'b1;
    repeat (26) tick();
    check("pre_rst_edge", edge_cnt, 2);
    Reset = 1'b0;
    #1;
    check("rst_mid_outs", outs(), 0);
    repeat (3) tick();
    Reset = 1'b1;
    repeat (70) tick();
    check("rst_no_pulse", n_dv + n_fe + n_pe, 0);
    clr_mon();
    send_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0);
    repeat (3) tick();
    check("post_rst_dv", n_dv, 1);
    check("post_rst_deser", n_deser, 8);

    check("pulses_exclusive", excl_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
